// File: rtl/sound_xmt.sv
// Sound-link UART transmitter: host-loaded 2**ADDR_W x WORD_W buffer.
// A start pulse sends LEN words as 8N1 frames, LSB byte first.
module sound_xmt #(
  parameter int M       = 3,
  parameter int SB_TICK = 16,
  parameter int ADDR_W  = 9,
  parameter int WORD_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wren,
  input  logic [ADDR_W-1:0] wraddress,
  input  logic [WORD_W-1:0] data,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
  output logic              tx,
  output logic              busy,
  output logic              done_tick
);

  localparam int CNT_W = (M > 1) ? $clog2(M) : 1;
  localparam int BYTES = WORD_W / 8;
  localparam int BI_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int S_W   = $clog2((SB_TICK > 16) ? SB_TICK : 16);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, STRT, DATA, STOP, NEXT} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [S_W-1:0]    s_reg, s_next;
  logic [2:0]        n_reg, n_next;
  logic [BI_W-1:0]   byte_reg, byte_next;
  logic [WORD_W-1:0] word_reg, word_next;
  logic [ADDR_W-1:0] rd_addr_reg, rd_addr_next;
  logic [ADDR_W:0]   wcnt_reg, wcnt_next;
  logic [ADDR_W:0]   len_reg, len_next;
  logic              tx_reg, tx_next;
  logic              busy_reg, busy_next;
  logic              done;
  logic              tick;

  logic [WORD_W-1:0] mem [2**ADDR_W];
  logic [WORD_W-1:0] rd_data_reg;

  // Read-before-write: a same-edge write to the read address returns old data.
  always_ff @(posedge clk) begin
    if (wren)
      mem[wraddress] <= data;
    rd_data_reg <= mem[rd_addr_reg];
  end

  assign tick = (cnt_reg == CNT_W'(M - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      s_reg       <= '0;
      n_reg       <= '0;
      byte_reg    <= '0;
      word_reg    <= '0;
      rd_addr_reg <= '0;
      wcnt_reg    <= '0;
      len_reg     <= '0;
      tx_reg      <= 1'b1;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      s_reg       <= s_next;
      n_reg       <= n_next;
      byte_reg    <= byte_next;
      word_reg    <= word_next;
      rd_addr_reg <= rd_addr_next;
      wcnt_reg    <= wcnt_next;
      len_reg     <= len_next;
      tx_reg      <= tx_next;
      busy_reg    <= busy_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = tick ? '0 : cnt_reg + 1'b1;
    s_next       = s_reg;
    n_next       = n_reg;
    byte_next    = byte_reg;
    word_next    = word_reg;
    rd_addr_next = rd_addr_reg;
    wcnt_next    = wcnt_reg;
    len_next     = len_reg;
    tx_next      = 1'b1;
    done         = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (start) begin
          // len of zero selects the full buffer
          len_next     = (len == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, len};
          rd_addr_next = '0;
          wcnt_next    = '0;
          state_next   = FETCH;
        end
      end
      FETCH: begin
        cnt_next   = '0;
        state_next = LOAD;
      end
      LOAD: begin
        cnt_next   = '0;
        word_next  = rd_data_reg;
        byte_next  = '0;
        s_next     = '0;
        state_next = STRT;
      end
      STRT: begin
        tx_next = 1'b0;
        if (tick) begin
          if (s_reg == S_W'(15)) begin
            s_next     = '0;
            n_next     = '0;
            state_next = DATA;
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      DATA: begin
        // The word shifts right one bit per data bit, so the next byte
        // is already at the bottom when its frame starts.
        tx_next = word_reg[0];
        if (tick) begin
          if (s_reg == S_W'(15)) begin
            s_next    = '0;
            word_next = word_reg >> 1;
            if (n_reg == 3'd7)
              state_next = STOP;
            else
              n_next = n_reg + 1'b1;
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s_reg == S_W'(SB_TICK - 1)) begin
            s_next = '0;
            if (byte_reg == BI_W'(BYTES - 1)) begin
              state_next = NEXT;
            end else begin
              byte_next  = byte_reg + 1'b1;
              state_next = STRT;
            end
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      NEXT: begin
        cnt_next = '0;
        if ((wcnt_reg + 1'b1) == len_reg) begin
          done       = 1'b1;
          state_next = IDLE;
        end else begin
          wcnt_next    = wcnt_reg + 1'b1;
          rd_addr_next = rd_addr_reg + 1'b1;
          state_next   = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy_next = (state_next != IDLE);
  assign tx        = tx_reg;
  assign busy      = busy_reg;
  assign done_tick = done;

endmodule

// File: tb/tb_sound_xmt.sv
// Directed bench for sound_xmt: a bit-exact 8N1 monitor decodes tx and the
// decoded bytes, frame start times, busy length and done_tick are checked.
module tb_sound_xmt;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wren = 1'b0;
  logic [8:0]  wraddress = '0;
  logic [31:0] data = '0;
  logic        start = 1'b0;
  logic [8:0]  len = '0;
  logic        tx, busy, done_tick;

  sound_xmt dut (
    .clk(clk), .rst(rst), .wren(wren), .wraddress(wraddress), .data(data),
    .start(start), .len(len), .tx(tx), .busy(busy), .done_tick(done_tick)
  );

  initial forever #5 clk = ~clk;

  int          cyc = 0;
  int          n_vec = 0;
  int          n_miss = 0;
  logic [7:0]  rx_q[$];
  int          fs_q[$];
  int          done_q[$];
  int          busy_cyc = 0;
  int          abort_cnt = 0;
  logic [31:0] mem_m [512];
  logic [31:0] exp_w [8];

  typedef struct {
    int          wlen;
    logic [31:0] base;
    logic [31:0] step;
    int          exp_frames;
    int          exp_busy;
  } vec_t;
  vec_t vt [3];

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial forever begin
    @(negedge clk);
    if (done_tick === 1'b1) done_q.push_back(cyc);
    if (busy === 1'b1) busy_cyc = busy_cyc + 1;
  end

  // 8N1 decoder sampling every clock; every bit must hold for exactly 48 clocks.
  initial begin : mon
    logic [7:0] rx;
    logic       bv;
    bit         ok;
    int         s0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && tx === 1'b0) begin
        s0 = cyc; ok = 1'b1; rx = '0; bv = 1'b0;
        for (int k = 1; k <= 456; k++) begin
          @(negedge clk);
          if (rst !== 1'b1) ok = 1'b0;
          if (k < 48) begin
            if (tx !== 1'b0) ok = 1'b0;
          end else if (k < 432) begin
            if (k % 48 == 0) begin
              bv = tx;
              rx[k/48-1] = tx;
            end else if (tx !== bv) begin
              ok = 1'b0;
            end
          end else if (tx !== 1'b1) begin
            ok = 1'b0;
          end
        end
        if (ok) begin
          fs_q.push_back(s0);
          rx_q.push_back(rx);
        end else begin
          abort_cnt = abort_cnt + 1;
        end
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    rx_q.delete(); fs_q.delete(); done_q.delete();
    busy_cyc = 0; abort_cnt = 0;
  endtask

  task automatic write_word(input int a, input logic [31:0] v);
    wren = 1'b1; wraddress = a[8:0]; data = v;
    @(negedge clk);
    wren = 1'b0;
    mem_m[a] = v;
  endtask

  // Sends l words; optional write / extra start pulse sampled at edge c0+wr_at / c0+st_at,
  // and an optional start pulse in the done_tick cycle.
  task automatic run_xfer(input int l, input int wr_at, input int wa, input logic [31:0] wv,
                          input int st_at, input bit st_done, output int c0);
    clear_mon();
    len = l[8:0]; start = 1'b1;
    @(negedge clk);
    c0 = cyc; start = 1'b0;
    for (int n = 0; n < 1923 * l + 200; n++) begin
      wren = (cyc == c0 + wr_at - 1);
      wraddress = wa[8:0]; data = wv;
      if (wren) mem_m[wa] = wv;
      start = (cyc == c0 + st_at - 1);
      len = 9'd1;
      @(negedge clk);
      if (done_tick === 1'b1) break;
    end
    wren = 1'b0;
    start = st_done;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic check_xfer(input string nm, input int l, input int c0,
                            input int exp_frames, input int exp_busy);
    check($sformatf("%s_frames", nm), rx_q.size(), exp_frames);
    for (int j = 0; j < exp_frames && j < rx_q.size(); j++) begin
      check($sformatf("%s_byte%0d", nm, j), rx_q[j], exp_w[j/4][8*(j%4) +: 8]);
      check($sformatf("%s_start%0d", nm, j), fs_q[j], c0 + 3 + 1923 * (j/4) + 480 * (j%4));
    end
    check($sformatf("%s_done_count", nm), done_q.size(), 1);
    if (done_q.size() > 0)
      check($sformatf("%s_done_time", nm), done_q[0], c0 + 1923 * l - 1);
    check($sformatf("%s_busy_len", nm), busy_cyc, exp_busy);
    check($sformatf("%s_aborts", nm), abort_cnt, 0);
  endtask

  initial begin
    int c0;
    int dn;
    vt[0] = '{1, 32'h44332211, 32'h0,        4,  1923};
    vt[1] = '{3, 32'hA5C30F81, 32'h01020304, 12, 5769};
    vt[2] = '{2, 32'h00FF7E01, 32'h10305070, 8,  3846};
    for (int i = 0; i < 512; i++) mem_m[i] = '0;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done_tick, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_tx", tx, 1);
    check("idle_busy", busy, 0);

    // table of basic transfers
    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < vt[v].wlen; i++) begin
        write_word(i, vt[v].base + vt[v].step * i);
        exp_w[i] = vt[v].base + vt[v].step * i;
      end
      run_xfer(vt[v].wlen, -100, 0, '0, -100, 1'b0, c0);
      check_xfer($sformatf("vec%0d", v), vt[v].wlen, c0, vt[v].exp_frames, vt[v].exp_busy);
    end

    // start ignored mid-transfer and in the done_tick cycle
    exp_w[0] = mem_m[0]; exp_w[1] = mem_m[1];
    run_xfer(2, -100, 0, '0, 1000, 1'b1, c0);
    check("restart_busy_after", busy, 0);
    check_xfer("restart", 2, c0, 8, 3846);

    // writes racing the FETCH of word 1
    write_word(0, 32'hCAFE0001);
    write_word(1, 32'h0BAD0002);
    exp_w[0] = 32'hCAFE0001; exp_w[1] = 32'h1234ABCD;
    run_xfer(2, 500, 1, 32'h1234ABCD, -100, 1'b0, c0);
    check_xfer("wr_early", 2, c0, 8, 3846);
    exp_w[1] = 32'h1234ABCD;
    run_xfer(2, 1924, 1, 32'h5555AAAA, -100, 1'b0, c0);
    check_xfer("wr_same_cycle", 2, c0, 8, 3846);
    exp_w[1] = 32'h77770001;
    run_xfer(2, 1923, 1, 32'h77770001, -100, 1'b0, c0);
    check_xfer("wr_edge_before", 2, c0, 8, 3846);

    // reset in the middle of data bit 2
    clear_mon();
    len = 9'd1; start = 1'b1;
    @(negedge clk);
    c0 = cyc; start = 1'b0;
    while (cyc < c0 + 3 + 48 * 3 + 10) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_tx", tx, 1);
    check("midrst_busy", busy, 0);
    check("midrst_done", done_tick, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (500) @(negedge clk);
    check("midrst_aborted", abort_cnt, 1);
    check("midrst_frames", rx_q.size(), 0);
    check("midrst_done_count", done_q.size(), 0);
    exp_w[0] = mem_m[0];
    run_xfer(1, -100, 0, '0, -100, 1'b0, c0);
    check_xfer("after_rst", 1, c0, 4, 1923);

    // len=0: full buffer; observe the first four ramp words, no early done
    for (int i = 0; i < 512; i++)
      write_word(i, {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
    clear_mon();
    len = 9'd0; start = 1'b1;
    @(negedge clk);
    c0 = cyc; start = 1'b0;
    dn = 0;
    while (cyc < c0 + 1923 * 4 + 20) begin
      @(negedge clk);
      if (done_tick === 1'b1) dn++;
    end
    check("len0_frames", rx_q.size(), 16);
    for (int j = 0; j < 16 && j < rx_q.size(); j++) begin
      check($sformatf("len0_byte%0d", j), rx_q[j], j);
      check($sformatf("len0_start%0d", j), fs_q[j], c0 + 3 + 1923 * (j/4) + 480 * (j%4));
    end
    check("len0_no_done", dn, 0);
    check("len0_busy", busy, 1);
    rst = 1'b0;
    repeat (500) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
